// File: rtl/mem_arb_pkg.sv
// Shared types and sizes for the 4-requester memory access arbiter.
// Pure declarations: no latency, no flow control.
package mem_arb_pkg;

  localparam int N_REQ  = 4;
  localparam int ID_W   = 2;
  localparam int BANK_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping 3->0.
// Zero latency; no flow control, the caller decides when the pick is used.
module rr_pick4
  import mem_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             any,
  output logic [ID_W-1:0]  winner_id
);

  logic [ID_W-1:0] idx;

  // Scan from the farthest candidate down to ptr so the nearest hit is kept last.
  always_comb begin
    any       = 1'b0;
    winner_id = ptr;
    idx       = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + ID_W'(k);
      if (req[idx]) begin
        any       = 1'b1;
        winner_id = idx;
      end
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin sequencer sharing one 4-bank memory port: grant+enable 1 cycle after request, read data 3 cycles after.
// Requesters hold req until their gnt pulse; req is only sampled while IDLE.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          mem_bank_en,
  output logic                      mem_we,
  output logic [ADDR_W-BANK_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic [ID_W-1:0]           rd_id,
  output logic                      busy
);

  localparam int OFF_W = ADDR_W - BANK_W;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   cur_id;
  logic              any;
  logic [ID_W-1:0]   winner;

  logic [ADDR_W-1:0] addr_arr  [N_REQ];
  logic [DATA_W-1:0] wdata_arr [N_REQ];
  logic [ADDR_W-1:0] win_addr;
  logic [BANK_W-1:0] win_bank;
  logic [N_REQ-1:0]  bank_dec;
  logic [N_REQ-1:0]  gnt_dec;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
      wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
    end
  end

  rr_pick4 u_pick (
    .req       (req),
    .ptr       (rr_ptr),
    .any       (any),
    .winner_id (winner)
  );

  always_comb begin
    win_addr         = addr_arr[winner];
    win_bank         = win_addr[ADDR_W-1 -: BANK_W];
    bank_dec         = '0;
    bank_dec[win_bank] = 1'b1;
    gnt_dec          = '0;
    gnt_dec[winner]  = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      cur_id      <= '0;
      gnt         <= '0;
      mem_bank_en <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      rd_id       <= '0;
      busy        <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            gnt         <= gnt_dec;
            mem_bank_en <= bank_dec;
            mem_we      <= req_we[winner];
            mem_addr    <= win_addr[OFF_W-1:0];
            mem_wdata   <= wdata_arr[winner];
            cur_id      <= winner;
            rr_ptr      <= winner + ID_W'(1);
            busy        <= 1'b1;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          gnt         <= '0;
          mem_bank_en <= '0;
          mem_we      <= 1'b0;
          // mem_we still holds the latched direction of this access.
          if (mem_we) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state <= RESP;
          end
        end
        RESP: begin
          rd_data  <= mem_rdata;
          rd_id    <= cur_id;
          rd_valid <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed and random checks of the arbiter against a cycle-level behavioural model
// and a flat byte-addressed reference memory.
module tb_mem_access_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  gnt, mem_bank_en;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic [1:0]  rd_id;
  logic        busy;

  always #5 clk = ~clk;

  mem_access_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .mem_bank_en(mem_bank_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_id(rd_id), .busy(busy)
  );

  // Bank array: read data appears the cycle after the enable cycle.
  logic [7:0] bank_mem [4][64];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_bank_en[b]) begin
        if (mem_we) bank_mem[b][mem_addr] <= mem_wdata;
        else        mem_rdata <= bank_mem[b][mem_addr];
      end
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference model: flat memory indexed by the full address, plus transaction phase.
  logic [7:0] ref_mem [256];
  int         m_phase;   // 0 free, 1 access cycle, 2 response cycle
  int         m_ptr;
  int         m_id;
  logic       m_we;
  logic [7:0] m_addr, m_wdata;

  logic [3:0] e_gnt, e_bank_en;
  logic       e_we, e_rd_valid, e_busy;
  logic [5:0] e_addr;
  logic [7:0] e_wdata, e_rd_data;
  logic [1:0] e_rd_id;
  logic [3:0] pend;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_now();
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("mem_bank_en", 32'(mem_bank_en), 32'(e_bank_en));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    if (e_bank_en != 4'b0) begin
      chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    end
    chk("rd_valid", 32'(rd_valid), 32'(e_rd_valid));
    if (e_rd_valid) begin
      chk("rd_data", 32'(rd_data), 32'(e_rd_data));
      chk("rd_id", 32'(rd_id), 32'(e_rd_id));
    end
    chk("busy", 32'(busy), 32'(e_busy));
  endtask

  // Predict next cycle's outputs from the current phase and the req seen at this edge.
  task automatic predict();
    bit found;
    e_gnt = 4'b0; e_bank_en = 4'b0; e_we = 1'b0; e_rd_valid = 1'b0; e_busy = 1'b0;
    case (m_phase)
      0: if (req != 4'b0) begin
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
          if (!found && req[(m_ptr + k) % 4]) begin
            found = 1'b1;
            m_id  = (m_ptr + k) % 4;
          end
        end
        m_we      = req_we[m_id];
        m_addr    = req_addr[m_id*8 +: 8];
        m_wdata   = req_wdata[m_id*8 +: 8];
        m_ptr     = (m_id + 1) % 4;
        e_gnt     = 4'b0001 << m_id;
        e_bank_en = 4'b0001 << (m_addr / 64);
        e_we      = m_we;
        e_addr    = 6'(m_addr % 64);
        e_wdata   = m_wdata;
        e_busy    = 1'b1;
        m_phase   = 1;
        if (m_we) ref_mem[m_addr] = m_wdata;
      end
      1: begin
        if (m_we) m_phase = 0;
        else begin
          m_phase = 2;
          e_busy  = 1'b1;
        end
      end
      default: begin
        e_rd_valid = 1'b1;
        e_rd_data  = ref_mem[m_addr];
        e_rd_id    = 2'(m_id);
        m_phase    = 0;
      end
    endcase
  endtask

  task automatic advance();
    predict();
    @(posedge clk);
    #1;
    check_now();
  endtask

  task automatic set_req(input int i, input logic we, input logic [7:0] a, input logic [7:0] d);
    req[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*8 +: 8] = a;
    req_wdata[i*8 +: 8] = d;
  endtask

  task automatic model_reset();
    m_phase = 0; m_ptr = 0;
    e_gnt = 4'b0; e_bank_en = 4'b0; e_we = 1'b0; e_rd_valid = 1'b0; e_busy = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0; pend = '0;
    model_reset();

    // Reset state
    #2;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_bank_en", 32'(mem_bank_en), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_rd_data", 32'(rd_data), 32'h0);
    chk("rst_rd_id", 32'(rd_id), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fill every location through the arbiter; 0x42 gets 0x99 for the read test.
    for (int a = 0; a < 256; a++) begin
      set_req(a % 4, 1'b1, 8'(a), (a == 8'h42) ? 8'h99 : 8'($urandom));
      advance();
      req = '0;
      advance();
    end

    // Single write from requester 2
    pulse_reset();
    set_req(2, 1'b1, 8'hC5, 8'h3A);
    advance();
    chk("sw_gnt", 32'(gnt), 32'b0100);
    chk("sw_bank_en", 32'(mem_bank_en), 32'b1000);
    chk("sw_we", 32'(mem_we), 32'h1);
    chk("sw_addr", 32'(mem_addr), 32'h05);
    chk("sw_wdata", 32'(mem_wdata), 32'h3A);
    req = '0;
    advance();
    chk("sw_busy_c2", 32'(busy), 32'h0);

    // Wrap and skip with the pointer at 3
    set_req(1, 1'b1, 8'h10, 8'h11);
    set_req(3, 1'b1, 8'h20, 8'h33);
    advance();
    chk("wrap_first", 32'(gnt), 32'b1000);
    req[3] = 1'b0;
    advance();
    advance();
    chk("wrap_second", 32'(gnt), 32'b0010);
    set_req(3, 1'b1, 8'h30, 8'h44);
    advance();
    chk("wrap_idle", 32'(gnt), 32'b0000);
    advance();
    chk("wrap_third", 32'(gnt), 32'b1000);
    req = '0;
    advance();

    // Single read from requester 0
    set_req(0, 1'b0, 8'h42, 8'h00);
    advance();
    chk("rd_bank_en", 32'(mem_bank_en), 32'b0010);
    chk("rd_addr", 32'(mem_addr), 32'h02);
    req = '0;
    advance();
    advance();
    chk("rd_valid_c3", 32'(rd_valid), 32'h1);
    chk("rd_data_c3", 32'(rd_data), 32'h99);
    chk("rd_id_c3", 32'(rd_id), 32'h0);

    // Late request raised during another requester's access
    set_req(0, 1'b1, 8'h05, 8'h55);
    advance();
    set_req(1, 1'b1, 8'h06, 8'h66);
    req[0] = 1'b0;
    advance();
    chk("late_idle_gnt", 32'(gnt), 32'b0000);
    advance();
    chk("late_gnt", 32'(gnt), 32'b0010);
    req = '0;
    advance();

    // Round-robin fairness: all four hold writes from reset
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'(8'h80 + i), 8'(i));
    pulse_reset();
    for (int k = 0; k < 5; k++) begin
      advance();
      chk("rr_gnt", 32'(gnt), 32'(4'b0001 << (k % 4)));
      advance();
      chk("rr_gap", 32'(gnt), 32'h0);
    end
    req = '0;
    advance();

    // Reset during RESP: read data is dropped
    set_req(2, 1'b0, 8'h77, 8'h00);
    advance();
    req = '0;
    advance();
    chk("mr_busy_resp", 32'(busy), 32'h1);
    rst = 1'b1;
    #2;
    chk("mr_busy", 32'(busy), 32'h0);
    chk("mr_gnt", 32'(gnt), 32'h0);
    chk("mr_addr", 32'(mem_addr), 32'h0);
    chk("mr_rd_valid", 32'(rd_valid), 32'h0);
    @(posedge clk);
    #1;
    chk("mr_no_rd_valid", 32'(rd_valid), 32'h0);
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'(8'h90 + i), 8'(8'hA0 + i));
    model_reset();
    rst = 1'b0;
    advance();
    chk("mr_next_gnt", 32'(gnt), 32'b0001);
    req = '0;
    advance();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(2) == 0) begin
          set_req(i, 1'($urandom_range(1)), 8'($urandom), 8'($urandom));
          pend[i] = 1'b1;
        end
      end
      advance();
      for (int i = 0; i < 4; i++) begin
        if (e_gnt[i]) begin
          if ($urandom_range(3) == 0) set_req(i, 1'($urandom_range(1)), 8'($urandom), 8'($urandom));
          else begin
            req[i]  = 1'b0;
            pend[i] = 1'b0;
          end
        end
      end
    end
    req = '0;
    for (int n = 0; n < 4; n++) advance();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
Round-robin arbiter and sequencer that shares the single port of the 4-bank instant-access memory between four requesters. It accepts one request at a time and splits the address into a 2-bit bank field and an in-bank offset. It drives one-hot bank enables, a write strobe, an address and write data, and returns read data tagged with the requester ID. It sits between the requester blocks and the memory bank array.

Parameters:
ADDR_W, 8, full request address width; bits [ADDR_W-1:ADDR_W-2] are the bank field, the remaining bits are the in-bank offset.
DATA_W, 8, data width.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
req  input  4  request per requester; held high until the matching gnt bit is seen.
req_we  input  4  per-requester write (1) or read (0); valid while req is high.
req_addr  input  4*ADDR_W  per-requester address; requester i uses slice [i*ADDR_W +: ADDR_W].
req_wdata  input  4*DATA_W  per-requester write data, sliced the same way.
gnt  output  4  one-hot, one-cycle pulse when a request is accepted.
mem_bank_en  output  4  one-hot bank enable, decoded from the bank field.
mem_we  output  1  write strobe.
mem_addr  output  ADDR_W-2  in-bank offset.
mem_wdata  output  DATA_W  write data.
mem_rdata  input  DATA_W  bank read data, valid one cycle after the enable cycle.
rd_valid  output  1  one-cycle pulse; read data is returned.
rd_data  output  DATA_W  returned read data.
rd_id  output  2  index of the requester that owns rd_data.
busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (asynchronous, active-high, clock-independent):
  - state=IDLE, rr_ptr=0.
  - gnt, mem_bank_en, mem_we, mem_addr, mem_wdata, rd_valid, rd_data, rd_id and busy all go to 0.
  - An in-flight read is discarded and no rd_valid is issued.
- All outputs are registered.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req bit is set, select the winner as the first set bit searching upward from rr_ptr, wrapping 3->0.
  - On the edge: latch the winner's we, addr and wdata; set gnt[winner]=1; rr_ptr <= winner+1 mod 4; go to ACCESS.
  - If no req bit is set, stay in IDLE and hold rr_ptr.
- ACCESS (exactly 1 cycle):
  - gnt is high for this cycle only.
  - mem_bank_en is the one-hot of the latched bank field: 00->0001, 01->0010, 10->0100, 11->1000.
  - mem_we equals the latched we; mem_addr and mem_wdata carry the latched values.
  - Next state: IDLE for a write, RESP for a read.
- RESP (1 cycle):
  - mem_bank_en=0 and mem_we=0.
  - On the edge: rd_data <= mem_rdata, rd_id <= winner, rd_valid <= 1 for one cycle; go to IDLE.
- Timing, with the request sampled in cycle 0:
  - gnt and the bank enable appear in cycle 1.
  - mem_rdata is sampled at the end of cycle 2.
  - rd_valid is high in cycle 3, which is an IDLE cycle, so new arbitration can occur in the same cycle.
  - Sustained throughput is 1 write per 2 cycles or 1 read per 3 cycles.
- Request changes while busy are ignored; req is sampled only in IDLE.
- A requester that keeps req high after gnt is treated as issuing a new request. Under contention it is served again only after every other active requester.
- Simultaneous requests: exactly one gnt per accepted request; gnt is never multi-hot.
- mem_bank_en is never multi-hot and is all-zero outside ACCESS.
- Address arithmetic is unsigned; the offset is passed through unchanged, with no wrap logic.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state enum {IDLE, ACCESS, RESP};
  - N_REQ=4, ID_W=2, BANK_W=2.
- One sub-module, rr_pick4:
  - combinational round-robin picker;
  - inputs req[3:0] and ptr[1:0]; outputs any, winner_id[1:0].
- Bank decode stays inline.

Test Plan:
- Single write: requester 2 issues a write to addr 8'hC5 with wdata 8'h3A, others idle.
  - Cycle 1: gnt=0100, mem_bank_en=1000, mem_we=1, mem_addr=6'h05, mem_wdata=3A.
  - Cycle 2: busy=0.
- Single read: requester 0 reads addr 8'h42; the memory model returns 8'h99.
  - Cycle 1: mem_bank_en=0010, mem_addr=6'h02.
  - Cycle 3: rd_valid=1, rd_data=99, rd_id=0.
- Round-robin fairness: all four requesters hold writes continuously from reset.
  - gnt order is 0001, 0010, 0100, 1000, 0001, with every grant 2 cycles apart.
- Wrap and skip: rr_ptr=3 with only requesters 1 and 3 active.
  - Requester 3 is granted first, then requester 1, then requester 3 again.
- Reset mid-read: assert rst during RESP.
  - All outputs go to 0 immediately, no rd_valid appears, and the next grant goes to requester 0 when all requesters are active.
- Late or changing requests while busy: requester 1 raises req during the ACCESS of requester 0.
  - Requester 1 is not granted before the following IDLE cycle, and its gnt appears exactly 1 cycle after that IDLE cycle.
